// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the SPI/core register file arbiter.
package regfile_arb_pkg;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned REG_N   = 1 << ADDR_W;
    localparam int unsigned RO_BASE = 8;

    // Control registers (host writable)
    localparam logic [ADDR_W-1:0] CTRL_MODE = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] CTRL_GATE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CTRL_THR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] CTRL_DIV  = ADDR_W'(3);

    // Result registers (host read-only)
    localparam logic [ADDR_W-1:0] RES_CNT0 = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] RES_CNT1 = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] RES_CNT2 = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] RES_CNT3 = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] RES_STAT = ADDR_W'(12);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_arb_if.sv
// Host (SPI memory bus) and core access signals of the register file arbiter.
interface regfile_arb_if;
    import regfile_arb_pkg::*;

    logic              spi_ss;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_wdata;
    logic              spi_wrt;
    logic [DATA_W-1:0] spi_rdata;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ack;

    logic              frame_lock;
    logic              cfg_upd;

    modport master (
        output spi_ss, spi_addr, spi_wdata, spi_wrt,
        output core_req, core_we, core_addr, core_wdata,
        input  spi_rdata, core_rdata, core_ack, frame_lock, cfg_upd
    );

    modport slave (
        input  spi_ss, spi_addr, spi_wdata, spi_wrt,
        input  core_req, core_we, core_addr, core_wdata,
        output spi_rdata, core_rdata, core_ack, frame_lock, cfg_upd
    );

endinterface

// File: rtl/regfile_arb_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module regfile_arb_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/regfile_arb.sv
// 16x8 register file shared by the SPI host and the measurement core; result
// registers are frozen against core writes while an SPI frame is active.
module regfile_arb
    import regfile_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    regfile_arb_if.slave  bus
);

    logic [DATA_W-1:0] regs [REG_N];
    state_e            state, state_nxt;
    logic              lock, lock_q, dirty, cfg_q, ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              host_wr_c, blocked_c, go_c, core_wr_c, fall_c;

    regfile_arb_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.spi_ss),
        .q   (lock)
    );

    assign host_wr_c = bus.spi_wrt && (bus.spi_addr < ADDR_W'(RO_BASE));
    assign fall_c    = lock_q && !lock;
    assign core_wr_c = go_c && bus.core_we;

    // Core waits on locked result writes and on a same-cycle host write to its address
    assign blocked_c = (bus.core_we && (bus.core_addr >= ADDR_W'(RO_BASE)) && lock)
                    || (bus.spi_wrt && bus.core_we && (bus.spi_addr == bus.core_addr));

    always_comb begin
        state_nxt = state;
        go_c      = 1'b0;
        case (state)
            ST_IDLE, ST_WAIT: begin
                if (bus.core_req) begin
                    if (blocked_c) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_ACCESS;
                        go_c      = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            lock_q  <= 1'b0;
            dirty   <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ack_q  <= go_c;
            lock_q <= lock;
            cfg_q  <= fall_c && dirty;
            dirty  <= fall_c ? host_wr_c : (dirty || host_wr_c);
            if (go_c && !bus.core_we) begin
                rdata_q <= regs[bus.core_addr];
            end
        end
    end

    // Both ports may land in one edge; same-address conflicts are stalled above
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (host_wr_c) begin
                regs[bus.spi_addr] <= bus.spi_wdata;
            end
            if (core_wr_c) begin
                regs[bus.core_addr] <= bus.core_wdata;
            end
        end
    end

    assign bus.spi_rdata  = regs[bus.spi_addr];
    assign bus.core_rdata = rdata_q;
    assign bus.core_ack   = ack_q;
    assign bus.frame_lock = lock;
    assign bus.cfg_upd    = cfg_q;

endmodule

// File: tb/tb_regfile_arb.sv
// Self-checking bench for regfile_arb: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_regfile_arb;
    import regfile_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_arb_if bus ();

    regfile_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_regs [16];
    logic       m_ss_d1, m_lock, m_lock_prev, m_dirty, m_cfg, m_ack, m_in_ack;
    logic [7:0] m_rdata;

    always @(posedge clk) begin : model
        logic fell, blk, hctrl, cwr;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            m_ss_d1 = 0; m_lock = 0; m_lock_prev = 0; m_dirty = 0;
            m_cfg = 0; m_ack = 0; m_in_ack = 0; m_rdata = 8'h00;
        end else begin
            hctrl = bus.spi_wrt && (int'(bus.spi_addr) < int'(RO_BASE));
            // Frame end pulse if any control write was seen since the last frame end
            fell  = m_lock_prev && !m_lock;
            m_cfg = fell && m_dirty;
            if (fell) m_dirty = 0;
            if (hctrl) m_dirty = 1;
            blk = (bus.core_we && int'(bus.core_addr) >= int'(RO_BASE) && m_lock) ||
                  (bus.spi_wrt && bus.core_we && bus.spi_addr == bus.core_addr);
            m_ack = 0;
            cwr   = 0;
            if (m_in_ack) begin
                m_in_ack = 0;
            end else if (bus.core_req && !blk) begin
                m_ack = 1;
                m_in_ack = 1;
                if (bus.core_we) cwr = 1;
                else m_rdata = m_regs[bus.core_addr];
            end
            if (hctrl) m_regs[bus.spi_addr] = bus.spi_wdata;
            if (cwr)   m_regs[bus.core_addr] = bus.core_wdata;
            // frame_lock is spi_ss as seen two edges ago
            m_lock_prev = m_lock;
            m_lock      = m_ss_d1;
            m_ss_d1     = bus.spi_ss;
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("frame_lock", 32'(bus.frame_lock), 32'(m_lock));
            check("cfg_upd", 32'(bus.cfg_upd), 32'(m_cfg));
            check("core_ack", 32'(bus.core_ack), 32'(m_ack));
            if (m_ack) check("core_rdata", 32'(bus.core_rdata), 32'(m_rdata));
            check("spi_rdata", 32'(bus.spi_rdata), 32'(m_regs[bus.spi_addr]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        bus.spi_wrt = 1; bus.spi_addr = a; bus.spi_wdata = d;
        step();
        bus.spi_wrt = 0;
    endtask

    task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        bus.spi_addr = a;
        #1;
        check(name, 32'(bus.spi_rdata), 32'(exp));
    endtask

    task automatic core_drive(input logic we, input logic [3:0] a, input logic [7:0] d);
        bus.core_req = 1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
    endtask

    task automatic core_op(input logic we, input logic [3:0] a, input logic [7:0] d, output int lat);
        core_drive(we, a, d);
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (bus.core_ack) begin lat = k; break; end
        end
        bus.core_req = 0;
    endtask

    task automatic count_cfg(input int n, output int cnt, output int first);
        cnt = 0; first = -1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (bus.cfg_upd) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic new_core_req();
        logic [3:0] a;
        a = ($urandom_range(0, 3) == 0) ? bus.spi_addr : 4'($urandom_range(0, 15));
        core_drive(1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_core_ack"}, 32'(bus.core_ack), 0);
        check({tag, "_cfg_upd"}, 32'(bus.cfg_upd), 0);
        check({tag, "_frame_lock"}, 32'(bus.frame_lock), 0);
        check({tag, "_core_rdata"}, 32'(bus.core_rdata), 0);
        for (int i = 0; i < 16; i++) host_read(4'(i), 8'h00, {tag, "_reg"});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, cnt, first, fall_at, ack_at, wait_cnt, frame_left, gap_left;
        bus.spi_ss = 0; bus.spi_addr = 0; bus.spi_wdata = 0; bus.spi_wrt = 0;
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
        #1 rst = 0;
        repeat (3) step();
        reset_checks("reset");
        rst = 1;
        chk_en = 1;
        step();

        // Host control write inside a frame, pulse after frame end
        bus.spi_ss = 1;
        repeat (3) step();
        host_write(CTRL_GATE, 8'h5A);
        step();
        bus.spi_ss = 0;
        count_cfg(8, cnt, first);
        check("cfg_upd_count_ctrl", 32'(cnt), 1);
        check("cfg_upd_delay_in_2_3", 32'(first >= 2 && first <= 3), 1);
        host_read(CTRL_GATE, 8'h5A, "host_ctrl_write");

        // Host write to a result register is ignored
        bus.spi_ss = 1;
        repeat (3) step();
        host_write(RES_CNT1, 8'hFF);
        step();
        bus.spi_ss = 0;
        count_cfg(8, cnt, first);
        check("cfg_upd_count_ro", 32'(cnt), 0);
        host_read(RES_CNT1, 8'h00, "host_ro_write_ignored");

        // Core write to a locked result register
        bus.spi_ss = 1;
        repeat (3) step();
        check("lock_asserted", 32'(bus.frame_lock), 1);
        core_drive(1, RES_CNT0, 8'h34);
        bus.spi_addr = RES_CNT0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.core_ack) cnt++;
        end
        check("locked_no_ack", 32'(cnt), 0);
        host_read(RES_CNT0, 8'h00, "locked_old_value");
        bus.spi_ss = 0;
        fall_at = -1; ack_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (!bus.frame_lock && fall_at < 0) fall_at = k;
            if (bus.core_ack) begin ack_at = k; break; end
        end
        bus.core_req = 0;
        check("locked_ack_after_unlock", 32'(ack_at - fall_at), 1);
        host_read(RES_CNT0, 8'h34, "locked_write_landed");

        // Baseline latency, then same-address collision
        step();
        core_op(1, CTRL_DIV, 8'h77, lat);
        check("core_write_latency", 32'(lat), 1);
        host_read(CTRL_DIV, 8'h77, "core_ctrl_write");
        step();
        bus.spi_wrt = 1; bus.spi_addr = CTRL_THR; bus.spi_wdata = 8'h11;
        core_drive(1, CTRL_THR, 8'h22);
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) bus.spi_wrt = 0;
            if (bus.core_ack) begin lat = k; break; end
        end
        bus.core_req = 0;
        check("collision_ack_latency", 32'(lat), 2);
        host_read(CTRL_THR, 8'h22, "collision_final");

        // Core read during a frame is not blocked
        step();
        bus.spi_ss = 1;
        repeat (3) step();
        core_op(0, CTRL_GATE, 8'h00, lat);
        check("frame_read_latency", 32'(lat), 1);
        check("frame_read_data", 32'(bus.core_rdata), 'h5A);
        bus.spi_ss = 0;
        repeat (4) step();

        // Reset mid-run with a pending locked write
        bus.spi_ss = 1;
        repeat (3) step();
        core_drive(1, RES_STAT, 8'hAB);
        repeat (2) step();
        rst = 0;
        bus.core_req = 0;
        bus.spi_ss = 0;
        #1;
        reset_checks("midrun_reset");
        repeat (2) step();
        rst = 1;
        repeat (4) step();
        host_read(RES_STAT, 8'h00, "reset_dropped_write");

        // Random traffic
        frame_left = 0; gap_left = 3; wait_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            bus.spi_wrt = 0;
            if (bus.spi_ss) begin
                if (frame_left == 0) begin bus.spi_ss = 0; gap_left = $urandom_range(2, 15); end
                else frame_left--;
            end else begin
                if (gap_left == 0) begin bus.spi_ss = 1; frame_left = $urandom_range(4, 40); end
                else gap_left--;
            end
            bus.spi_addr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                bus.spi_wrt = 1;
                bus.spi_wdata = 8'($urandom);
            end
            if (bus.core_req) begin
                if (bus.core_ack) begin
                    wait_cnt = 0;
                    if ($urandom_range(0, 2) == 0) new_core_req();
                    else bus.core_req = 0;
                end else begin
                    wait_cnt++;
                    if (wait_cnt == 300) begin
                        checks++;
                        errors++;
                        $display("FAIL core_wait_bound: waited %0d cycles, limit 300", wait_cnt);
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_core_req();
            end
        end
        bus.spi_wrt = 0;
        bus.spi_ss = 0;
        for (int k = 0; k < 60 && bus.core_req; k++) begin
            step();
            if (bus.core_ack) bus.core_req = 0;
        end
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
